// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// The operation is accepted in IDLE, iterates one bit per cycle for 32 cycles
// in RUN, and applies sign correction and the HI/LO write in FIX.
// Signed operations run on operand magnitudes. The signs are restored in FIX.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset
//   start       in   1   launch operation (from EX stage)
//   op          in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a       in  32   rs operand (dividend / multiplicand)
//   src_b       in  32   rt operand (divisor / multiplier)
//   flush       in   1   abort in-flight operation, suppress start in IDLE
//   hilo_we     in   1   MTHI/MTLO write strobe (only honoured when idle)
//   hilo_sel    in   1   0 writes LO, 1 writes HI
//   hilo_wdata  in  32   MTHI/MTLO data
//   busy        out  1   operation in flight
//   done        out  1   one-cycle pulse when HI/LO hold a new result
//   hi          out 32   HI register
//   lo          out 32   LO register
// ---------------------------------------------------------------------------
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Control state (reset)
    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    // Datapath state (not reset; always loaded on an accepted start)
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   m_q;
    logic                is_div_q;
    logic                neg_a_q;
    logic                neg_b_q;

    logic                accept;
    logic                signed_op;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] step;
    logic [2*DATA_W-1:0] result;

    // Two's-complement negate of a 32-bit value.
    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
        return ~x + 32'd1;
    endfunction

    // Sign correction of the 64-bit product magnitude.
    function automatic logic [2*DATA_W-1:0] fix_mul(input logic [2*DATA_W-1:0] mag,
                                                    input logic            neg);
        return neg ? (~mag + 64'd1) : mag;
    endfunction

    // Sign correction of quotient/remainder, returned as {hi, lo}.
    // On a zero divisor the remainder register has shifted in the whole
    // dividend magnitude untouched, so re-applying the dividend sign
    // reconstructs src_a exactly as it was latched.
    function automatic logic [2*DATA_W-1:0] fix_div(input logic [2*DATA_W-1:0] acc,
                                                    input logic            na,
                                                    input logic            nb,
                                                    input logic [DATA_W-1:0] divisor);
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] r_fix;
        q     = acc[DATA_W-1:0];
        r     = acc[2*DATA_W-1:DATA_W];
        r_fix = na ? neg32(r) : r;
        if (divisor == '0) begin
            return {r_fix, 32'hFFFF_FFFF};
        end
        return {r_fix, (na ^ nb) ? neg32(q) : q};
    endfunction

    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign signed_op = ~op[0];
    assign neg_a     = signed_op & src_a[DATA_W-1];
    assign neg_b     = signed_op & src_b[DATA_W-1];
    assign mag_a     = neg_a ? neg32(src_a) : src_a;
    assign mag_b     = neg_b ? neg32(src_b) : src_b;

    // One iteration. acc holds {upper, lower}:
    //   multiply: upper = partial product, lower = remaining multiplier bits
    //   divide:   upper = partial remainder, lower = dividend bits / quotient
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        step      = acc_q;
        if (is_div_q) begin
            // diff[32] is the borrow: set means the trial subtraction failed.
            if (!div_diff[DATA_W]) begin
                step = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            end else begin
                step = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            step = {mul_sum, acc_q[DATA_W-1:1]};
        end
    end

    assign result = is_div_q ? fix_div(acc_q, neg_a_q, neg_b_q, m_q)
                             : fix_mul(acc_q, neg_a_q ^ neg_b_q);

    // Next-state / output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = hilo_wdata;
                    else          lo_d = hilo_wdata;
                end
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    hi_d   = result[2*DATA_W-1:DATA_W];
                    lo_d   = result[DATA_W-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q <= op[1];
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            if (op[1]) begin
                acc_q <= {32'd0, mag_a};
                m_q   <= mag_b;
            end else begin
                acc_q <= {32'd0, mag_b};
                m_q   <= mag_a;
            end
        end else if (state_q == S_RUN) begin
            acc_q <= step;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hilo_we    (hilo_we),
        .hilo_sel   (hilo_sel),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} straight from 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for busy to fall, then checks length, done pulse and result.
    task automatic finish_op(input string tag, input logic [63:0] exp, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (busy && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, {63'd0, done}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        launch(o, a, b);
        finish_op(tag, model(o, a, b), 0);
    endtask

    initial begin
        logic        seen_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        #20;
        @(negedge clk);
        reset = 1'b0;

        // Directed examples
        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg3x5 const_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_neg3x5 const_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max const_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_2 const_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf const_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0);
        check("divu_by0 const_hi", {32'd0, hi}, 64'h0000_0000_0000_0064);
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);

        // Preload HI/LO through the MTHI/MTLO path
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234_5678;
        @(negedge clk);
        hilo_sel = 1'b0;
        @(negedge clk);
        hilo_we = 1'b0;
        check("preload hi", {32'd0, hi}, 64'h1234_5678);
        check("preload lo", {32'd0, lo}, 64'h1234_5678);

        // DIVU with start and hilo_we injected mid-RUN, then flush on RUN cycle 10
        launch(2'b11, 32'd1000, 32'd3);
        check("flush busy_after_start", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hDEAD_BEEF;
                start = 1'b1; op = 2'b01;
            end
            if (k == 4) begin
                hilo_we = 1'b0; start = 1'b0;
            end
            if (k == 10) flush = 1'b1;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        seen_done = done;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done;
        end
        check("flush no_done", {63'd0, seen_done}, 64'd0);
        check("flush busy_stays_low", {63'd0, busy}, 64'd0);
        check("flush hi", {32'd0, hi}, 64'h1234_5678);
        check("flush lo", {32'd0, lo}, 64'h1234_5678);

        // Start during RUN with new operands must not re-latch
        launch(2'b11, 32'd100, 32'd7);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd6;
            end
            if (k == 6) start = 1'b0;
        end
        finish_op("start_ignored", {32'd2, 32'd14}, 5);

        // Async reset in the middle of RUN cycle 20
        launch(2'b01, 32'h0001_2345, 32'h0000_0777);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset busy", {63'd0, busy}, 64'd0);
        check("areset hi", {32'd0, hi}, 64'd0);
        check("areset lo", {32'd0, lo}, 64'd0);
        check("areset done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        run_op("after_reset_3x4", 2'b01, 32'd3, 32'd4);
        check("after_reset const_lo", {32'd0, lo}, 64'd12);

        // Flush during FIX: no write, no done
        launch(2'b01, 32'd7, 32'd9);
        repeat (32) @(posedge clk);
        #1;
        check("fixflush in_fix_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fixflush busy", {63'd0, busy}, 64'd0);
        check("fixflush done", {63'd0, done}, 64'd0);
        check("fixflush hi", {32'd0, hi}, 64'd0);
        check("fixflush lo", {32'd0, lo}, 64'd12);

        // Flush together with start in IDLE suppresses the start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("idleflush busy", {63'd0, busy}, 64'd0);

        // hilo_we with an accepted start: write happens, result overwrites later
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hA5A5_A5A5;
        start = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        @(posedge clk);
        #1;
        hilo_we = 1'b0; start = 1'b0;
        check("we_start hi_written", {32'd0, hi}, 64'hA5A5_A5A5);
        check("we_start busy", {63'd0, busy}, 64'd1);
        finish_op("we_start", model(2'b00, 32'hFFFF_FFFE, 32'd3), 0);

        // Randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       ra = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if (i == 0) rb = $urandom;
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
